// File: rtl/bash_msg_packer.sv
// Packs a 32-bit AXI4-Stream message into 1024-bit BASH rate blocks and pads the final block.
// Latency: block_valid_o rises the cycle after the beat that completes a block.
// Backpressure: tready drops while a block is held or a pad-only block is built; the block is held until block_ready_i.
module bash_msg_packer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SLEN     = 64,
  parameter int unsigned NLANES   = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h40
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic [XLEN-1:0]          s_axis_tdata,
  input  logic [XLEN/8-1:0]        s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [NLANES*SLEN-1:0]   block_o,
  output logic                     block_valid_o,
  output logic                     block_last_o,
  input  logic                     block_ready_i,
  output logic [31:0]              msg_bytes_o,
  output logic                     err_o
);

  localparam int unsigned BLKW   = NLANES * SLEN;
  localparam int unsigned NWORDS = BLKW / XLEN;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned IDXW   = $clog2(NWORDS);
  localparam int unsigned CNTW   = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [BLKW-1:0]   buf_q, buf_d;
  logic              last_q, last_d;
  logic              pad_pend_q, pad_pend_d;
  logic [31:0]       bytes_q, bytes_d;
  logic              new_msg_q, new_msg_d;
  logic              err_q, err_d;

  logic              beat;
  logic [CNTW-1:0]   keep_cnt;
  logic              keep_legal;
  logic [NBYTES-1:0] keep_mask;
  logic [XLEN-1:0]   last_word;
  logic [CNTW-1:0]   beat_bytes;

  // tready is forced low while reset is asserted, then follows the FILL state
  assign s_axis_tready = (state_q == FILL) && s_axi_aresetn;
  assign beat          = s_axis_tvalid && s_axis_tready;
  assign block_o       = buf_q;
  assign block_valid_o = (state_q == HOLD);
  assign block_last_o  = last_q;
  assign msg_bytes_o   = bytes_q;
  assign err_o         = err_q;

  // Byte count of the tlast beat, legality of its keep pattern, and the padded word it produces
  always_comb begin
    keep_cnt   = '0;
    keep_legal = 1'b0;
    keep_mask  = '0;
    last_word  = '0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      keep_cnt = keep_cnt + CNTW'(s_axis_tkeep[b]);
    end
    // Legal patterns are the contiguous masks 0, 1, 11, 111, ...
    for (int n = 0; n <= int'(NBYTES); n++) begin
      if (s_axis_tkeep == keep_mask) begin
        keep_legal = 1'b1;
      end
      keep_mask = {keep_mask[NBYTES-2:0], 1'b1};
    end
    // Illegal patterns are still processed by popcount: low bytes kept, pad byte right after
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (b < int'(keep_cnt)) begin
        last_word[8*b +: 8] = s_axis_tdata[8*b +: 8];
      end else if (b == int'(keep_cnt)) begin
        last_word[8*b +: 8] = PAD_BYTE;
      end
    end
    beat_bytes = s_axis_tlast ? keep_cnt : CNTW'(NBYTES);
  end

  // Next-state logic: fill words, pad on tlast, hold block until the consumer takes it
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    bytes_d    = bytes_q;
    new_msg_d  = new_msg_q;
    err_d      = err_q;
    case (state_q)
      FILL: begin
        if (beat) begin
          idx_d     = idx_q + 1'b1;
          new_msg_d = s_axis_tlast;
          bytes_d   = (new_msg_q ? 32'd0 : bytes_q) + 32'(beat_bytes);
          if (s_axis_tlast) begin
            buf_d[XLEN*int'(idx_q) +: XLEN] = last_word;
            err_d   = err_q | ~keep_legal;
            state_d = HOLD;
            if (int'(keep_cnt) < int'(NBYTES)) begin
              last_d = 1'b1;
            end else if (int'(idx_q) != int'(NWORDS) - 1) begin
              // Full last word: the pad byte opens the next word of this block
              buf_d[XLEN*(int'(idx_q) + 1) +: XLEN] = XLEN'(PAD_BYTE);
              last_d = 1'b1;
            end else begin
              // Message ends exactly on a block boundary: a pad-only block follows
              last_d     = 1'b0;
              pad_pend_d = 1'b1;
            end
          end else begin
            buf_d[XLEN*int'(idx_q) +: XLEN] = s_axis_tdata;
            if (int'(idx_q) == int'(NWORDS) - 1) begin
              last_d  = 1'b0;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (block_ready_i) begin
          buf_d   = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = pad_pend_q ? PADBLK : FILL;
        end
      end
      PADBLK: begin
        buf_d[XLEN-1:0] = XLEN'(PAD_BYTE);
        pad_pend_d      = 1'b0;
        last_d          = 1'b1;
        state_d         = HOLD;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers; reset discards any partial block
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= FILL;
      idx_q      <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      bytes_q    <= '0;
      new_msg_q  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
      bytes_q    <= bytes_d;
      new_msg_q  <= new_msg_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_bash_msg_packer.sv
// Self-checking bench for bash_msg_packer: expected blocks queued at stimulus time, compared at handshake.
// Latency: n/a (testbench).
// Backpressure: exercised via block_ready_i held low during one scenario.
module tb_bash_msg_packer;

  logic          clk;
  logic          rst_n;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [1023:0] blk;
  logic          blk_vld;
  logic          blk_last;
  logic          blk_rdy;
  logic [31:0]   msg_bytes;
  logic          err;

  typedef struct {
    logic [1023:0] blk;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t mon_e;
  int   mon_bad;

  bash_msg_packer dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .block_o       (blk),
    .block_valid_o (blk_vld),
    .block_last_o  (blk_last),
    .block_ready_i (blk_rdy),
    .msg_bytes_o   (msg_bytes),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each block handshake pops one expected block
  always @(negedge clk) begin
    if (rst_n && blk_vld && blk_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_block: got word0=%h last=%b, required no block", blk[31:0], blk_last);
      end else begin
        mon_e   = sb.pop_front();
        mon_bad = -1;
        for (int k = 31; k >= 0; k--) begin
          if (blk[32*k +: 32] !== mon_e.blk[32*k +: 32]) mon_bad = k;
        end
        n_cmp++;
        if (mon_bad >= 0) begin
          n_err++;
          $display("FAIL block_data word%0d: got %h, required %h", mon_bad,
                   blk[32*mon_bad +: 32], mon_e.blk[32*mon_bad +: 32]);
        end
        n_cmp++;
        if (blk_last !== mon_e.last) begin
          n_err++;
          $display("FAIL block_last: got %b, required %b", blk_last, mon_e.last);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    t      = 0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    @(negedge clk);
    while (tready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_err++;
      $display("FAIL beat_accept_timeout: got tready=%b after %0d cycles, required 1", tready, t);
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(posedge clk); #2;
    while (!(sb.size() == 0 && tready === 1'b1 && blk_vld === 1'b0) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    n_cmp++;
    if (t >= 500) begin
      n_err++;
      $display("FAIL %s_drain: got %0d blocks outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({tready, blk_vld, blk_last, err} !== 4'b0000 || msg_bytes !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b err=%b bytes=%0d, required 0 0 0 0 0",
               tready, blk_vld, blk_last, err, msg_bytes);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tready !== 1'b1 || blk_vld !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got rdy=%b vld=%b, required 1 0", tready, blk_vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_block_pad();
    exp_t e;
    e.blk = '0;
    for (int k = 0; k < 32; k++) e.blk[32*k +: 32] = k;
    e.last = 1'b0;
    sb.push_back(e);
    e.blk = '0;
    e.blk[31:0] = 32'h0000_0040;
    e.last = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 32; k++) send_beat(32'(k), 4'hF, k == 31);
    wait_idle("full_block_pad");
    n_cmp++;
    if (msg_bytes !== 32'd128) begin
      n_err++;
      $display("FAIL full_block_bytes: got %0d, required 128", msg_bytes);
    end
  endtask

  task automatic test_partial_last();
    exp_t e;
    e.blk = '0;
    e.blk[31:0]  = 32'h1111_1111;
    e.blk[63:32] = 32'h2222_2222;
    e.blk[95:64] = 32'h0040_CCDD;
    e.last = 1'b1;
    sb.push_back(e);
    send_beat(32'h1111_1111, 4'hF, 1'b0);
    send_beat(32'h2222_2222, 4'hF, 1'b0);
    send_beat(32'hAABB_CCDD, 4'b0011, 1'b1);
    wait_idle("partial_last");
    n_cmp++;
    if (msg_bytes !== 32'd10) begin
      n_err++;
      $display("FAIL partial_bytes: got %0d, required 10", msg_bytes);
    end
  endtask

  task automatic test_full_last_word();
    exp_t e;
    e.blk = '0;
    for (int k = 0; k < 5; k++) e.blk[32*k +: 32] = 32'h100 + k;
    e.blk[32*5 +: 32] = 32'h0000_0040;
    e.last = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 5; k++) send_beat(32'h100 + k, 4'hF, k == 4);
    wait_idle("full_last_word");
    n_cmp++;
    if (msg_bytes !== 32'd20) begin
      n_err++;
      $display("FAIL five_beat_bytes: got %0d, required 20", msg_bytes);
    end
  endtask

  task automatic test_empty_msg();
    exp_t e;
    e.blk = '0;
    e.blk[31:0] = 32'h0000_0040;
    e.last = 1'b1;
    sb.push_back(e);
    send_beat(32'hDEAD_BEEF, 4'b0000, 1'b1);
    wait_idle("empty_msg");
    n_cmp++;
    if (msg_bytes !== 32'd0) begin
      n_err++;
      $display("FAIL empty_bytes: got %0d, required 0", msg_bytes);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   t;
    int   bad;
    e.blk = '0;
    for (int k = 0; k < 31; k++) e.blk[32*k +: 32] = 32'hC0DE_0000 + k;
    e.blk[32*31 +: 32] = 32'h40DE_001F;
    e.last = 1'b1;
    sb.push_back(e);
    blk_rdy = 1'b0;
    for (int k = 0; k < 32; k++) send_beat(32'hC0DE_0000 + k, (k == 31) ? 4'b0111 : 4'hF, k == 31);
    t = 0;
    @(negedge clk);
    while (blk_vld !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (blk_vld !== 1'b1) begin
      n_err++;
      $display("FAIL hold_valid_rise: got vld=%b, required 1", blk_vld);
    end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (tready !== 1'b0 || blk_vld !== 1'b1 || blk !== e.blk) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_stable: got %0d bad cycles of 50, required 0", bad);
    end
    @(posedge clk); #1;
    blk_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (tready !== 1'b1 || blk_vld !== 1'b0) begin
      n_err++;
      $display("FAIL release_ready: got rdy=%b vld=%b, required 1 0", tready, blk_vld);
    end
    n_cmp++;
    if (msg_bytes !== 32'd127 || sb.size() != 0) begin
      n_err++;
      $display("FAIL release_state: got bytes=%0d pending=%0d, required 127 0", msg_bytes, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midblock();
    exp_t e;
    for (int k = 0; k < 10; k++) send_beat(32'h5000 + k, 4'hF, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (tready !== 1'b0 || msg_bytes !== 32'd0 || blk_vld !== 1'b0) begin
      n_err++;
      $display("FAIL midblock_reset: got rdy=%b bytes=%0d vld=%b, required 0 0 0", tready, msg_bytes, blk_vld);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    e.blk = '0;
    e.blk[31:0] = 32'h0000_40A5;
    e.last = 1'b1;
    sb.push_back(e);
    send_beat(32'h1234_56A5, 4'b0001, 1'b1);
    wait_idle("after_reset");
    n_cmp++;
    if (err !== 1'b0 || msg_bytes !== 32'd1) begin
      n_err++;
      $display("FAIL after_reset_status: got err=%b bytes=%0d, required 0 1", err, msg_bytes);
    end
  endtask

  task automatic test_bad_keep();
    exp_t e;
    e.blk = '0;
    e.blk[31:0] = 32'h0040_3344;
    e.last = 1'b1;
    sb.push_back(e);
    send_beat(32'h1122_3344, 4'b0101, 1'b1);
    wait_idle("bad_keep");
    n_cmp++;
    if (err !== 1'b1 || msg_bytes !== 32'd2) begin
      n_err++;
      $display("FAIL bad_keep_status: got err=%b bytes=%0d, required 1 2", err, msg_bytes);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tdata   = '0;
    tkeep   = '0;
    tlast   = 1'b0;
    tvalid  = 1'b0;
    blk_rdy = 1'b1;
    test_reset();
    test_full_block_pad();
    test_partial_last();
    test_full_last_word();
    test_empty_msg();
    test_backpressure();
    test_reset_midblock();
    test_bad_keep();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover_blocks: got %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
